// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch address and sequences IDLE/RUN/HALT,
// with sequential increment, jump/branch redirect, stall, halt detection and misalign flag.
module pc_sequencer #(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    INSTR_BYTES = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    HALT_REPEAT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_ready,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [DATA_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [DATA_WIDTH-1:0] jump_target,
    input  logic                  restart,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic                  fetch_en,
    output logic                  prog_ack,
    output logic                  misalign_err
);

    localparam int ALIGN_W = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam int CNT_W   = $clog2(HALT_REPEAT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t                  state;
    logic [CNT_W-1:0]        halt_cnt;
    logic                    redirect;
    logic                    self_loop;

    function automatic logic is_misaligned(input logic [DATA_WIDTH-1:0] addr);
        if (INSTR_BYTES <= 1)
            return 1'b0;
        return addr[ALIGN_W-1:0] != '0;
    endfunction

    // Next-PC select: stall > jump > branch > sequential; frozen outside RUN
    always_comb begin
        pc_next  = pc_out;
        redirect = 1'b0;
        if (state == S_RUN && !stall) begin
            if (jump) begin
                pc_next  = jump_target;
                redirect = 1'b1;
            end else if (branch_taken) begin
                pc_next  = branch_target;
                redirect = 1'b1;
            end else begin
                pc_next  = pc_out + DATA_WIDTH'(INSTR_BYTES);
            end
        end
    end

    assign self_loop = (pc_next == pc_out);
    assign fetch_en  = (state == S_RUN) && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc_out       <= RESET_PC;
            halt_cnt     <= '0;
            prog_ack     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            // Sticky error: only a redirect that is actually taken can set it
            if (!restart && redirect && is_misaligned(pc_next))
                misalign_err <= 1'b1;

            if (restart) begin
                state    <= S_IDLE;
                pc_out   <= RESET_PC;
                halt_cnt <= '0;
                prog_ack <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (prog_ready)
                            state <= S_RUN;
                    end
                    S_RUN: begin
                        pc_out <= pc_next;
                        // Stalled cycles leave the self-loop count untouched
                        if (!stall) begin
                            if (self_loop) begin
                                halt_cnt <= halt_cnt + 1'b1;
                                if (halt_cnt == CNT_W'(HALT_REPEAT - 1)) begin
                                    state    <= S_HALT;
                                    prog_ack <= 1'b1;
                                end
                            end else begin
                                halt_cnt <= '0;
                            end
                        end
                    end
                    S_HALT: begin
                        prog_ack <= 1'b1;
                    end
                    default: begin
                        state    <= S_IDLE;
                        pc_out   <= RESET_PC;
                        halt_cnt <= '0;
                        prog_ack <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_sequencer;

    localparam int          DW      = 32;
    localparam int          IB      = 4;
    localparam logic [31:0] RST_PC  = 32'h0;
    localparam int          HREP    = 2;
    localparam int          M_IDLE  = 0;
    localparam int          M_RUN   = 1;
    localparam int          M_HALT  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          prog_ready = 1'b0;
    logic          stall = 1'b0;
    logic          branch_taken = 1'b0;
    logic [31:0]   branch_target = '0;
    logic          jump = 1'b0;
    logic [31:0]   jump_target = '0;
    logic          restart = 1'b0;
    logic [31:0]   pc_out;
    logic [31:0]   pc_next;
    logic          fetch_en;
    logic          prog_ack;
    logic          misalign_err;

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model state
    int          m_state = M_IDLE;
    logic [31:0] m_pc    = RST_PC;
    int          m_cnt   = 0;
    logic        m_ack   = 1'b0;
    logic        m_err   = 1'b0;

    // Values seen on the combinational outputs during the last step, and the model's view
    logic [31:0] obs_next;
    logic        obs_fe;
    logic [31:0] exp_next;
    logic        exp_fe;

    pc_sequencer #(
        .DATA_WIDTH (DW),
        .INSTR_BYTES(IB),
        .RESET_PC   (RST_PC),
        .HALT_REPEAT(HREP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .prog_ready   (prog_ready),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .restart      (restart),
        .pc_out       (pc_out),
        .pc_next      (pc_next),
        .fetch_en     (fetch_en),
        .prog_ack     (prog_ack),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        rst = 0; prog_ready = 0; stall = 0; branch_taken = 0; jump = 0; restart = 0;
    endtask

    // One clock: sample combinational outputs, advance the clock, advance the model.
    task automatic step();
        logic [31:0] np;
        #1;
        obs_next = pc_next;
        obs_fe   = fetch_en;
        exp_fe   = (m_state == M_RUN) && !stall;
        if (m_state != M_RUN || stall) np = m_pc;
        else if (jump)                 np = jump_target;
        else if (branch_taken)         np = branch_target;
        else                           np = m_pc + 32'd4;
        exp_next = np;
        @(posedge clk);
        if (rst) begin
            m_state = M_IDLE; m_pc = RST_PC; m_cnt = 0; m_ack = 0; m_err = 0;
        end else if (restart) begin
            m_state = M_IDLE; m_pc = RST_PC; m_cnt = 0; m_ack = 0;
        end else if (m_state == M_IDLE) begin
            if (prog_ready) m_state = M_RUN;
        end else if (m_state == M_RUN && !stall) begin
            if ((jump || branch_taken) && (np % IB) != 0) m_err = 1;
            m_cnt = (np == m_pc) ? m_cnt + 1 : 0;
            m_pc  = np;
            if (m_cnt == HREP) begin
                m_state = M_HALT;
                m_ack   = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; step(); rst = 0;
        n_checks++;
        if ({pc_out, prog_ack, misalign_err} !== {32'h0, 1'b0, 1'b0}) begin
            n_fails++;
            $display("FAIL reset_state: got pc=%h ack=%b err=%b, want pc=0 ack=0 err=0", pc_out, prog_ack, misalign_err);
        end
        step();
        n_checks++;
        if (obs_fe !== 1'b0 || pc_out !== 32'h0 || obs_next !== 32'h0) begin
            n_fails++;
            $display("FAIL idle_frozen: got fe=%b pc=%h next=%h, want fe=0 pc=0 next=0", obs_fe, pc_out, obs_next);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        prog_ready = 1; step(); prog_ready = 0;
        n_checks++;
        if (pc_out !== 32'h0) begin
            n_fails++;
            $display("FAIL start_pc: got %h want 0", pc_out);
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            want = 32'(i * 4);
            n_checks++;
            if (pc_out !== want || obs_fe !== 1'b1) begin
                n_fails++;
                $display("FAIL seq_step%0d: got pc=%h fe=%b, want pc=%h fe=1", i, pc_out, obs_fe, want);
            end
        end
    endtask

    task automatic test_redirect();
        jump = 1; jump_target = 32'h100; branch_taken = 1; branch_target = 32'h200;
        step();
        n_checks++;
        if (pc_out !== 32'h100 || obs_next !== 32'h100) begin
            n_fails++;
            $display("FAIL jump_over_branch: got pc=%h next=%h want 100", pc_out, obs_next);
        end
        jump = 0; branch_target = 32'h40;
        step();
        branch_taken = 0;
        n_checks++;
        if (pc_out !== 32'h40) begin
            n_fails++;
            $display("FAIL branch: got pc=%h want 40", pc_out);
        end
    endtask

    task automatic test_stall();
        stall = 1; jump = 1; jump_target = 32'h80;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (pc_out !== 32'h40 || obs_fe !== 1'b0) begin
                n_fails++;
                $display("FAIL stall_hold%0d: got pc=%h fe=%b, want pc=40 fe=0", i, pc_out, obs_fe);
            end
        end
        clear_inputs();
        step();
        n_checks++;
        if (pc_out !== 32'h44 || obs_fe !== 1'b1) begin
            n_fails++;
            $display("FAIL stall_resume: got pc=%h fe=%b, want pc=44 fe=1", pc_out, obs_fe);
        end
    endtask

    task automatic test_halt();
        jump = 1; jump_target = 32'h20;
        step();
        step();
        n_checks++;
        if (prog_ack !== 1'b0 || pc_out !== 32'h20) begin
            n_fails++;
            $display("FAIL halt_early: got ack=%b pc=%h, want ack=0 pc=20", prog_ack, pc_out);
        end
        step();
        n_checks++;
        if (prog_ack !== 1'b1) begin
            n_fails++;
            $display("FAIL halt_ack: got ack=%b want 1", prog_ack);
        end
        step();
        n_checks++;
        if (obs_fe !== 1'b0 || pc_out !== 32'h20) begin
            n_fails++;
            $display("FAIL halt_frozen: got fe=%b pc=%h, want fe=0 pc=20", obs_fe, pc_out);
        end
        clear_inputs();
        restart = 1; step(); restart = 0;
        n_checks++;
        if (pc_out !== 32'h0 || prog_ack !== 1'b0) begin
            n_fails++;
            $display("FAIL restart: got pc=%h ack=%b, want pc=0 ack=0", pc_out, prog_ack);
        end
        // One stall between self-jumps delays the halt by a cycle
        prog_ready = 1; step(); prog_ready = 0;
        jump = 1; jump_target = 32'h20;
        step();
        step();
        stall = 1; step(); stall = 0;
        n_checks++;
        if (prog_ack !== 1'b0) begin
            n_fails++;
            $display("FAIL halt_stall_delay: got ack=%b want 0", prog_ack);
        end
        step();
        n_checks++;
        if (prog_ack !== 1'b1) begin
            n_fails++;
            $display("FAIL halt_after_stall: got ack=%b want 1", prog_ack);
        end
        clear_inputs();
        prog_ready = 1; step(); prog_ready = 0;
        n_checks++;
        if (prog_ack !== 1'b1 || pc_out !== 32'h20) begin
            n_fails++;
            $display("FAIL ready_in_halt: got ack=%b pc=%h, want ack=1 pc=20", prog_ack, pc_out);
        end
        prog_ready = 1; restart = 1; step(); clear_inputs();
        step();
        n_checks++;
        if (prog_ack !== 1'b0 || obs_fe !== 1'b0 || pc_out !== 32'h0) begin
            n_fails++;
            $display("FAIL restart_beats_ready: got ack=%b fe=%b pc=%h, want 0 0 0", prog_ack, obs_fe, pc_out);
        end
    endtask

    task automatic test_misalign();
        prog_ready = 1; step(); prog_ready = 0;
        branch_taken = 1; branch_target = 32'h102; step(); branch_taken = 0;
        n_checks++;
        if (pc_out !== 32'h102 || misalign_err !== 1'b1) begin
            n_fails++;
            $display("FAIL misalign_set: got pc=%h err=%b, want pc=102 err=1", pc_out, misalign_err);
        end
        restart = 1; step(); restart = 0;
        n_checks++;
        if (misalign_err !== 1'b1) begin
            n_fails++;
            $display("FAIL misalign_sticky: got err=%b want 1", misalign_err);
        end
        rst = 1; step(); rst = 0;
        n_checks++;
        if (misalign_err !== 1'b0) begin
            n_fails++;
            $display("FAIL misalign_rst: got err=%b want 0", misalign_err);
        end
    endtask

    task automatic test_wrap_and_rst();
        prog_ready = 1; step(); prog_ready = 0;
        jump = 1; jump_target = 32'hFFFF_FFF8; step(); jump = 0;
        step();
        step();
        n_checks++;
        if (pc_out !== 32'h0 || obs_next !== 32'h0 || misalign_err !== 1'b0) begin
            n_fails++;
            $display("FAIL wrap: got pc=%h next=%h err=%b, want pc=0 next=0 err=0", pc_out, obs_next, misalign_err);
        end
        jump = 1; jump_target = 32'h2C; step(); jump = 0;
        step();
        n_checks++;
        if (pc_out !== 32'h30) begin
            n_fails++;
            $display("FAIL pre_rst_pc: got %h want 30", pc_out);
        end
        rst = 1; step(); rst = 0;
        step();
        n_checks++;
        if (pc_out !== RST_PC || obs_fe !== 1'b0) begin
            n_fails++;
            $display("FAIL rst_mid_run: got pc=%h fe=%b, want pc=%h fe=0", pc_out, obs_fe, RST_PC);
        end
    endtask

    function automatic logic [31:0] pick_target();
        int r = $urandom_range(0, 9);
        if (r < 3) return m_pc;
        if (r < 4) return (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
        if (r < 5) return 32'hFFFF_FFFC;
        return 32'($urandom_range(0, 255)) << 2;
    endfunction

    task automatic test_random();
        clear_inputs();
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 600; i++) begin
            rst           = ($urandom_range(0, 99) == 0);
            restart       = ($urandom_range(0, 39) == 0);
            prog_ready    = ($urandom_range(0, 7) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            jump          = ($urandom_range(0, 7) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            jump_target   = pick_target();
            branch_target = pick_target();
            step();
            n_checks++;
            if ({pc_out, prog_ack, misalign_err, obs_next, obs_fe} !== {m_pc, m_ack, m_err, exp_next, exp_fe}) begin
                n_fails++;
                $display("FAIL random_%0d: got pc=%h ack=%b err=%b next=%h fe=%b, want pc=%h ack=%b err=%b next=%h fe=%b",
                         i, pc_out, prog_ack, misalign_err, obs_next, obs_fe, m_pc, m_ack, m_err, exp_next, exp_fe);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_halt();
        test_misalign();
        test_wrap_and_rst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
